// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Hands the shared 4-port SDRAM FIFOs back and forth between the camera/VGA
// path and the HPS neural-net path. Ownership only moves at a camera
// end-of-frame once the write FIFOs have drained. Every ownership change is
// wrapped in an oLOAD pulse, so oSEL_NN never changes without a FIFO reload.
// Optional feature: define SDRAM_ARB_WATCHDOG_EN to build the NN occupancy
// watchdog (forced release after NN_WDOG_CYCLES cycles, flagged in oERR[1]).
//
// NN handshake: the HPS holds iNN_REQ high for as long as it wants the ports.
// oNN_GRANT rises only after the reload into NN has finished, and the HPS may
// touch the FIFOs only while oNN_GRANT is high. The HPS gives the ports back
// with iNN_DONE (pulse or level) or by dropping iNN_REQ. oNN_GRANT falls on the
// same edge that starts the reload back to the camera.
module sdram_port_arbiter #(
    parameter int LOAD_CYCLES   = 4,
    parameter int DRAIN_TIMEOUT = 1024
`ifdef SDRAM_ARB_WATCHDOG_EN
    ,
    parameter int NN_WDOG_CYCLES = 1 << 20
`endif
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iFVAL,
    input  logic       iWR_EMPTY,
    input  logic       iNN_REQ,
    input  logic       iNN_DONE,
    input  logic       iERR_CLR,
    output logic       oSEL_NN,
    output logic       oLOAD,
    output logic       oCAM_EN,
    output logic       oNN_GRANT,
    output logic [7:0] oSESSIONS,
    output logic [1:0] oERR,
    output logic [2:0] oDBG_STATE
);

    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [LW-1:0] LOAD_LAST  = LW'(LOAD_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CAM      = 3'd0,
        S_WAIT_EOF = 3'd1,
        S_DRAIN    = 3'd2,
        S_LOAD_NN  = 3'd3,
        S_NN       = 3'd4,
        S_LOAD_CAM = 3'd5
    } state_t;

    state_t          state;
    logic            fval_q;
    logic            empty_q;
    logic [DW-1:0]   drain_cnt;
    logic [LW-1:0]   load_cnt;
    logic            fval_fall;
    logic            drain_done;
    logic            drain_expire;
    logic            nn_release;
    logic            wdog_expire;

    assign oDBG_STATE = state;

    // End of frame: FVAL was high last cycle and is low now.
    assign fval_fall    = fval_q & ~iFVAL;
    // Write FIFOs count as drained only after two consecutive empty samples.
    assign drain_done   = iWR_EMPTY & empty_q;
    assign drain_expire = (state == S_DRAIN) && !drain_done && (drain_cnt == DRAIN_LAST);
    assign nn_release   = iNN_DONE | ~iNN_REQ;

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam int WW = (NN_WDOG_CYCLES > 1) ? $clog2(NN_WDOG_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(NN_WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt;

    assign wdog_expire = (state == S_NN) && !nn_release && (wdog_cnt == WDOG_LAST);

    // NN occupancy counter: runs only while NN owns the ports, zero otherwise.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wdog_cnt <= '0;
        end else if (state == S_NN) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    assign wdog_expire = 1'b0;
`endif

    // Single registered sample of FVAL for end-of-frame detection.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fval_q <= 1'b0;
        end else begin
            fval_q <= iFVAL;
        end
    end

    // Ownership sequencer; every output is registered alongside the state.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= S_CAM;
            oSEL_NN   <= 1'b0;
            oLOAD     <= 1'b0;
            oCAM_EN   <= 1'b1;
            oNN_GRANT <= 1'b0;
            oSESSIONS <= 8'd0;
            drain_cnt <= '0;
            load_cnt  <= '0;
            empty_q   <= 1'b0;
        end else begin
            case (state)
                S_CAM: begin
                    if (iNN_REQ) begin
                        state <= S_WAIT_EOF;
                    end
                end
                S_WAIT_EOF: begin
                    // A dropped request beats a simultaneous end of frame.
                    if (!iNN_REQ) begin
                        state <= S_CAM;
                    end else if (fval_fall) begin
                        state     <= S_DRAIN;
                        oCAM_EN   <= 1'b0;
                        drain_cnt <= '0;
                        empty_q   <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    empty_q   <= iWR_EMPTY;
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_done || drain_expire) begin
                        state    <= S_LOAD_NN;
                        oSEL_NN  <= 1'b1;
                        oLOAD    <= 1'b1;
                        load_cnt <= '0;
                    end
                end
                S_LOAD_NN: begin
                    if (load_cnt == LOAD_LAST) begin
                        state     <= S_NN;
                        oLOAD     <= 1'b0;
                        oNN_GRANT <= 1'b1;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                S_NN: begin
                    if (nn_release || wdog_expire) begin
                        state     <= S_LOAD_CAM;
                        oNN_GRANT <= 1'b0;
                        oSEL_NN   <= 1'b0;
                        oLOAD     <= 1'b1;
                        load_cnt  <= '0;
                    end
                end
                S_LOAD_CAM: begin
                    if (load_cnt == LOAD_LAST) begin
                        state     <= S_CAM;
                        oLOAD     <= 1'b0;
                        oCAM_EN   <= 1'b1;
                        oSESSIONS <= oSESSIONS + 1'b1;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_CAM;
                end
            endcase
        end
    end

    // Sticky error flags; a new error outranks a clear in the same cycle.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oERR <= 2'b00;
        end else begin
            oERR <= (iERR_CLR ? 2'b00 : oERR) | {wdog_expire, drain_expire};
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
// Randomised sessions against a transaction-level model: each expected oLOAD
// pulse is queued as a record when stimulus is issued, and a negedge monitor
// pops and compares a record whenever the DUT finishes a pulse.
module tb_sdram_port_arbiter;

    localparam int LOAD_CYCLES   = 4;
    localparam int DRAIN_TIMEOUT = 1024;
`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam int NN_WDOG_CYCLES = 64;
`endif
    // record: {sel@start, err@start[1:0], width[7:0], grant@end, cam_en@end, sessions@end[7:0]}
    localparam int W = 21;

    logic       clk = 1'b0;
    logic       rst;
    logic       fval;
    logic       wr_empty;
    logic       nn_req;
    logic       nn_done;
    logic       err_clr;
    logic       sel_nn;
    logic       load;
    logic       cam_en;
    logic       nn_grant;
    logic [7:0] sessions;
    logic [1:0] err;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           exp_sessions = 0;
    logic [1:0]   exp_err = 2'b00;

    sdram_port_arbiter #(
        .LOAD_CYCLES  (LOAD_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
`ifdef SDRAM_ARB_WATCHDOG_EN
        ,
        .NN_WDOG_CYCLES(NN_WDOG_CYCLES)
`endif
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iFVAL     (fval),
        .iWR_EMPTY (wr_empty),
        .iNN_REQ   (nn_req),
        .iNN_DONE  (nn_done),
        .iERR_CLR  (err_clr),
        .oSEL_NN   (sel_nn),
        .oLOAD     (load),
        .oCAM_EN   (cam_en),
        .oNN_GRANT (nn_grant),
        .oSESSIONS (sessions),
        .oERR      (err),
        .oDBG_STATE(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk_rec(input logic s, input logic [1:0] e, input int w,
                                            input logic g, input logic c, input int n);
        logic [7:0] w8;
        logic [7:0] n8;
        w8 = w[7:0];
        n8 = n[7:0];
        return {s, e, w8, g, c, n8};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_grant(input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (nn_grant !== val && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (nn_grant !== val) begin
            errors++;
            $display("FAIL %s grant stuck at %b expected %b after %0d cycles", name, nn_grant, val, budget);
        end
    endtask

    task automatic wait_cam(input int budget, input string name);
        int n;
        n = 0;
        while (cam_en !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (cam_en !== 1'b1) begin
            errors++;
            $display("FAIL %s cam_en still %b after %0d cycles", name, cam_en, budget);
        end
    endtask

    // Take the ports for NN: request during a frame, end the frame, drain.
    task automatic enter_nn(input int k_empty, input logic [1:0] err_at_start);
        fval = 1'b1;
        cyc($urandom_range(1, 5));
        nn_req = 1'b1;
        cyc($urandom_range(2, 10));
        wr_empty = 1'b0;
        fval = 1'b0;
        exp_q.push_back(mk_rec(1'b1, err_at_start, LOAD_CYCLES, 1'b1, 1'b0, exp_sessions));
        cyc(k_empty);
        wr_empty = 1'b1;
        wait_grant(1'b1, 200, "grant_on");
        check("cam_en_in_nn", cam_en, 0);
        check("sel_in_nn", sel_nn, 1);
    endtask

    // Give the ports back, either by DONE (REQ kept high) or by dropping REQ.
    task automatic leave_nn(input bit by_done);
        exp_sessions = (exp_sessions + 1) % 256;
        exp_q.push_back(mk_rec(1'b0, exp_err, LOAD_CYCLES, 1'b0, 1'b1, exp_sessions));
        if (by_done) begin
            nn_done = 1'b1;
            cyc(1);
            nn_done = 1'b0;
        end else begin
            nn_req = 1'b0;
        end
        wait_cam(50, "cam_return");
        check("sessions_after", sessions, exp_sessions);
        if (by_done) begin
            // REQ still high: a new request is pending, but no frame end arrives.
            cyc(3);
            nn_req = 1'b0;
            cyc(3);
        end
        check("sel_after", sel_nn, 0);
    endtask

    // Drain that never sees two consecutive empties; returns DRAIN length.
    task automatic drain_timeout(input bit alternate, input bit clr_hold, output int cnt);
        int n;
        fval = 1'b1;
        cyc(3);
        nn_req = 1'b1;
        cyc(3);
        wr_empty = alternate ? 1'b1 : 1'b0;
        err_clr = clr_hold;
        fval = 1'b0;
        exp_err = clr_hold ? 2'b01 : (exp_err | 2'b01);
        exp_q.push_back(mk_rec(1'b1, exp_err, LOAD_CYCLES, 1'b1, 1'b0, exp_sessions));
        cnt = 0;
        n = 0;
        while (load !== 1'b1 && n < 3000) begin
            if (cam_en === 1'b0) cnt++;
            if (alternate) wr_empty = ~wr_empty;
            cyc(1);
            n++;
        end
        err_clr = 1'b0;
        wr_empty = 1'b1;
        wait_grant(1'b1, 50, "grant_after_timeout");
        check("err_after_timeout", err, exp_err);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic         mon_prev_load = 1'b0;
    logic         mon_prev_sel = 1'b0;
    logic         mon_sel = 1'b0;
    logic [1:0]   mon_err = 2'b00;
    int           mon_width = 0;
    logic [W-1:0] got_rec;
    logic [W-1:0] exp_rec;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev_load = 1'b0;
            mon_prev_sel = 1'b0;
            mon_width = 0;
        end else begin
            if (sel_nn !== mon_prev_sel) begin
                checks++;
                if (load !== 1'b1) begin
                    errors++;
                    $display("FAIL sel_without_load sel %b load %b at %0t", sel_nn, load, $time);
                end
            end
            if (load && !mon_prev_load) begin
                mon_sel = sel_nn;
                mon_err = err;
                mon_width = 1;
            end else if (load) begin
                mon_width++;
            end else if (mon_prev_load) begin
                got_rec = mk_rec(mon_sel, mon_err, mon_width, nn_grant, cam_en, int'(sessions));
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse sel %b err %b width %0d grant %b cam %b sess %0d at %0t",
                             got_rec[20], got_rec[19:18], got_rec[17:10], got_rec[9], got_rec[8],
                             got_rec[7:0], $time);
                end else begin
                    exp_rec = exp_q.pop_front();
                    if (got_rec !== exp_rec) begin
                        errors++;
                        $display("FAIL pulse got sel %b err %b width %0d grant %b cam %b sess %0d; expected sel %b err %b width %0d grant %b cam %b sess %0d at %0t",
                                 got_rec[20], got_rec[19:18], got_rec[17:10], got_rec[9], got_rec[8], got_rec[7:0],
                                 exp_rec[20], exp_rec[19:18], exp_rec[17:10], exp_rec[9], exp_rec[8], exp_rec[7:0],
                                 $time);
                    end
                end
            end
            mon_prev_load = load;
            mon_prev_sel = sel_nn;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        bit bad;

        rst = 1'b1;
        fval = 1'b0;
        wr_empty = 1'b0;
        nn_req = 1'b0;
        nn_done = 1'b0;
        err_clr = 1'b0;
        cyc(3);
        check("rst_sel", sel_nn, 0);
        check("rst_load", load, 0);
        check("rst_cam_en", cam_en, 1);
        check("rst_grant", nn_grant, 0);
        check("rst_sessions", sessions, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        cyc(2);

        // Idle camera with FVAL toggling: nothing may move.
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            fval = 1'($urandom_range(0, 1));
            wr_empty = 1'($urandom_range(0, 1));
            nn_done = 1'($urandom_range(0, 1));
            cyc(1);
            if (sel_nn !== 1'b0 || cam_en !== 1'b1 || load !== 1'b0 || nn_grant !== 1'b0) bad = 1'b1;
        end
        nn_done = 1'b0;
        fval = 1'b0;
        cyc(2);
        check("idle_stable", int'(bad), 0);

        // Request withdrawn before end of frame.
        fval = 1'b1;
        cyc(3);
        nn_req = 1'b1;
        cyc($urandom_range(2, 6));
        nn_req = 1'b0;
        cyc(2);
        fval = 1'b0;
        cyc(6);
        check("abort_cam_en", cam_en, 1);
        check("abort_sessions", sessions, exp_sessions);

        // Request dropped in the same cycle FVAL falls: the drop wins.
        fval = 1'b1;
        cyc(3);
        nn_req = 1'b1;
        cyc(4);
        nn_req = 1'b0;
        fval = 1'b0;
        cyc(6);
        check("tie_cam_en", cam_en, 1);
        check("tie_sel", sel_nn, 0);

        // Full sessions, enough to wrap the session counter past 255.
        for (int s = 0; s < 258; s++) begin
            enter_nn($urandom_range(0, 12), exp_err);
            cyc($urandom_range(1, 12));
            leave_nn(bit'($urandom_range(0, 1)));
        end
        check("sessions_wrapped", sessions, 2);

        // Drain timeout with EMPTY held low, then clear the error.
        drain_timeout(1'b0, 1'b0, cnt);
        check("drain_len_held0", cnt, DRAIN_TIMEOUT);
        leave_nn(1'b0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        exp_err = 2'b00;
        check("err_cleared", err, 0);

        // Alternating EMPTY never qualifies; clear held across the timeout edge.
        drain_timeout(1'b1, 1'b1, cnt);
        check("drain_len_alt", cnt, DRAIN_TIMEOUT);
        leave_nn(1'b1);

        // Asynchronous reset in the middle of an NN session.
        enter_nn($urandom_range(0, 5), exp_err);
        cyc($urandom_range(2, 20));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_grant", nn_grant, 0);
        check("midrst_sel", sel_nn, 0);
        check("midrst_load", load, 0);
        check("midrst_sessions", sessions, 0);
        check("midrst_err", err, 0);
        check("midrst_cam_en", cam_en, 1);
        nn_req = 1'b0;
        exp_sessions = 0;
        exp_err = 2'b00;
        cyc(2);
        rst = 1'b0;
        cyc(3);

        // NN never says DONE.
        enter_nn($urandom_range(0, 5), exp_err);
`ifdef SDRAM_ARB_WATCHDOG_EN
        exp_err = exp_err | 2'b10;
        exp_sessions = (exp_sessions + 1) % 256;
        exp_q.push_back(mk_rec(1'b0, exp_err, LOAD_CYCLES, 1'b0, 1'b1, exp_sessions));
        cnt = 0;
        while (nn_grant === 1'b1 && cnt < 500) begin
            cnt++;
            cyc(1);
        end
        check("wdog_grant_len", cnt, NN_WDOG_CYCLES);
        wait_cam(50, "wdog_cam_return");
        check("wdog_err", err, exp_err);
        check("wdog_sessions", sessions, exp_sessions);
        nn_req = 1'b0;
        cyc(4);
`else
        cyc(10000);
        check("nowdog_still_granted", nn_grant, 1);
        check("nowdog_err1", err[1], 0);
        leave_nn(1'b1);
`endif

        cyc(20);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
